// File: rtl/seq_squarer_mul.sv
// Sequential shift-add squarer/multiplier with valid/ready handshakes on both sides.
// Retires BPC multiplier bits per cycle; result is full 2*WIDTH precision.
module seq_squarer_mul #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               op_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic               busy
);

  localparam int N     = WIDTH / BPC;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = 2 * WIDTH;
  localparam int SH_W  = $clog2(ACC_W);
  localparam int PP_W  = WIDTH + BPC;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   out_data_q;

  logic [PP_W-1:0]    pp;
  logic [SH_W-1:0]    shamt;
  logic [ACC_W-1:0]   acc_next;
  logic               last_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      CALC:    busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  // Partial product of the multiplicand with the low BPC multiplier bits.
  always_comb begin
    pp = '0;
    for (int i = 0; i < BPC; i++) begin
      if (mplier[i]) begin
        pp = pp + (PP_W'(mcand) << i);
      end
    end
  end

  assign shamt     = SH_W'(cnt) * SH_W'(BPC);
  assign acc_next  = acc + (ACC_W'(pp) << shamt);
  assign last_step = (cnt == CNT_W'(N - 1));

  // The result register is loaded with the final sum and left untouched afterwards,
  // so the sink keeps seeing the last result after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      out_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= in_a;
            mplier <= op_sel ? in_a : in_b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mplier <= mplier >> BPC;
          cnt    <= cnt + CNT_W'(1);
          if (last_step) begin
            out_data_q <= acc_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data = out_data_q;

endmodule
